fwrisc_mem_arbiter: RTL and testbench
=====================================

FWRISC_MEM_ARBITER -- requirements
Module: fwrisc_mem_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_PRIORITY, default 1; 1 = data port wins every conflict, 0 = round-robin on conflict.
REQ-002 The module SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have ports iaddr input 32, ivalid input 1: instruction fetch request address and request strobe.
REQ-005 The module SHALL have ports idata output 32, iready output 1: fetch read data and completion pulse.
REQ-006 The module SHALL have ports daddr input 32, dwdata input 32, dwstb input 4, dwrite input 1, dvalid input 1: data request.
REQ-007 The module SHALL have ports drdata output 32, dready output 1: data read data and completion pulse.
REQ-008 The module SHALL have ports maddr output 32, mwdata output 32, mwstb output 4, mwrite output 1, mvalid output 1: shared memory request.
REQ-009 The module SHALL have ports mrdata input 32, mready input 1: shared memory response.

Function
REQ-010 The arbiter SHALL implement states IDLE, IACT and DACT.
REQ-011 In IDLE with only ivalid=1, the next state SHALL be IACT; with only dvalid=1, DACT; with neither, IDLE.
REQ-012 In IDLE with ivalid=dvalid=1 and DATA_PRIORITY=1, the next state SHALL be DACT.
REQ-013 In IDLE with ivalid=dvalid=1 and DATA_PRIORITY=0, the port not granted most recently SHALL be granted.
REQ-014 The last-grant register SHALL update only on entry to IACT or DACT.
REQ-015 On the IDLE->IACT edge, the arbiter SHALL register maddr=iaddr, mwdata=0, mwstb=0, mwrite=0.
REQ-016 On the IDLE->DACT edge, the arbiter SHALL register maddr=daddr, mwdata=dwdata, mwstb=dwstb, mwrite=dwrite.
REQ-017 mvalid SHALL be 1 exactly while in IACT or DACT; maddr, mwdata, mwstb and mwrite SHALL be stable for that whole interval.
REQ-018 In IACT/DACT with mready=0, the state SHALL hold; there SHALL be no timeout.
REQ-019 In IACT with mready=1, iready SHALL be 1 in that same cycle (combinational) with idata=mrdata, and the next state SHALL be IDLE.
REQ-020 In DACT with mready=1, dready SHALL be 1 in that same cycle with drdata=mrdata, and the next state SHALL be IDLE.
REQ-021 iready and dready SHALL be single-cycle pulses and SHALL never both be 1.
REQ-022 idata and drdata SHALL be 0 whenever the corresponding ready is 0.
REQ-023 Minimum latency SHALL be: request seen at cycle N, mvalid at N+1, ready at N+1 if mready=1, IDLE at N+2.
REQ-024 Back-to-back transactions SHALL therefore have a 1-cycle IDLE gap.
REQ-025 mready while in IDLE SHALL be ignored.
REQ-026 A request deasserted after being latched SHALL still complete on the memory side; its ready pulse SHALL still be generated.
REQ-027 Requesters hold valid and request fields until their ready; the arbiter SHALL not sample request fields outside IDLE.
REQ-028 With DATA_PRIORITY=0 and both ports continuously requesting, grants SHALL strictly alternate D, I, D, I, ...

Reset
REQ-029 While reset=1 at a clock edge, the next state SHALL be IDLE, last-grant SHALL be I, and maddr, mwdata, mwstb, mwrite SHALL be 0.
REQ-030 With state IDLE after reset, mvalid SHALL be 0, iready and dready SHALL be 0, and idata and drdata SHALL be 0.
REQ-031 Reset asserted during IACT/DACT SHALL abandon the transaction: mvalid is 0 the next cycle and no ready pulse is issued, even if mready=1 in the reset cycle.

Verification
REQ-032 Fetch only: ivalid=1, iaddr=0x100, mready=1 at N+1, mrdata=0x00000013 -> mvalid=1, maddr=0x100, mwrite=0 at N+1; iready=1, idata=0x13 at N+1.
REQ-033 Store: dvalid=1, daddr=0x2000, dwdata=0xDEADBEEF, dwstb=0xF, dwrite=1, mready held 0 for 3 cycles then 1 -> mvalid high 4 cycles with stable fields; single dready pulse.
REQ-034 Conflict, DATA_PRIORITY=1: ivalid=dvalid=1 -> grant order D then I; ready pulses ordered dready then iready; IDLE gap between them.
REQ-035 Conflict, DATA_PRIORITY=0: both valid for 4 transactions after reset -> grant order D, I, D, I.
REQ-036 Reset mid-DACT with mready=1 in the reset cycle -> no dready; mvalid=0, maddr=0 the following cycle.
REQ-037 Stray mready=1 in IDLE -> no ready pulse and no state change.

Source files
------------

// File: rtl/fwrisc_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared memory bus.
// One transaction in flight at a time; request fields are latched on grant.
module fwrisc_mem_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic [31:0] drdata,
  output logic        dready,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic [31:0] mrdata,
  input  logic        mready,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is accepted only in IDLE; the memory side holds
  // mvalid with stable fields until mready, and the matching ready pulses in
  // that same cycle with the read data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACT = 2'd1,
    DACT = 2'd2
  } state_t;

  state_t state;
  logic   last_d;   // 1 when the data port held the most recent grant
  logic   grant_d;

  assign grant_d = dvalid && (!ivalid || DATA_PRIORITY || !last_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      mwstb  <= '0;
      mwrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= DACT;
            last_d <= 1'b1;
            maddr  <= daddr;
            mwdata <= dwdata;
            mwstb  <= dwstb;
            mwrite <= dwrite;
          end else if (ivalid) begin
            state  <= IACT;
            last_d <= 1'b0;
            maddr  <= iaddr;
            mwdata <= '0;
            mwstb  <= '0;
            mwrite <= 1'b0;
          end
        end
        IACT, DACT: begin
          if (mready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing on the completing cycle abandons the transaction silently.
  assign mvalid    = (state == IACT) || (state == DACT);
  assign iready    = (state == IACT) && mready && !reset;
  assign dready    = (state == DACT) && mready && !reset;
  assign idata     = iready ? mrdata : 32'h0;
  assign drdata    = dready ? mrdata : 32'h0;
  assign dbg_state = state;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Bench for fwrisc_mem_arbiter: a data-priority and a round-robin instance share
// stimulus; each is checked every cycle against a transaction-level model.
module tb_fwrisc_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic [3:0]  dwstb = '0;
  logic        ivalid = 1'b0, dvalid = 1'b0, dwrite = 1'b0, mready = 1'b0;

  logic [31:0] idata_w[2], drdata_w[2], maddr_w[2], mwdata_w[2];
  logic [3:0]  mwstb_w[2];
  logic        iready_w[2], dready_w[2], mwrite_w[2], mvalid_w[2];
  logic [1:0]  dbg_w[2];

  int tests = 0;
  int fails = 0;

  // Grant-order scoreboard for the round-robin instance: 1 = data, 0 = fetch.
  logic [0:0] exp_q[$];
  bit         sb_on = 1'b0;

  // Reference model: one in-flight transaction record per instance.
  bit          prio[2] = '{1'b1, 1'b0};
  bit          busy[2], who_d[2], last_was_d[2];
  logic [31:0] t_addr[2], t_wdata[2];
  logic [3:0]  t_wstb[2];
  logic        t_write[2];

  always #5 clock = ~clock;

  fwrisc_mem_arbiter #(.DATA_PRIORITY(1'b1)) dut_dp (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .idata(idata_w[0]), .iready(iready_w[0]),
    .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite), .dvalid(dvalid),
    .drdata(drdata_w[0]), .dready(dready_w[0]),
    .maddr(maddr_w[0]), .mwdata(mwdata_w[0]), .mwstb(mwstb_w[0]), .mwrite(mwrite_w[0]),
    .mvalid(mvalid_w[0]), .mrdata(mrdata), .mready(mready), .dbg_state(dbg_w[0])
  );

  fwrisc_mem_arbiter #(.DATA_PRIORITY(1'b0)) dut_rr (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .idata(idata_w[1]), .iready(iready_w[1]),
    .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite), .dvalid(dvalid),
    .drdata(drdata_w[1]), .dready(dready_w[1]),
    .maddr(maddr_w[1]), .mwdata(mwdata_w[1]), .mwstb(mwstb_w[1]), .mwrite(mwrite_w[1]),
    .mvalid(mvalid_w[1]), .mrdata(mrdata), .mready(mready), .dbg_state(dbg_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; who_d[k] = 1'b0; last_was_d[k] = 1'b0;
      t_addr[k] = '0; t_wdata[k] = '0; t_wstb[k] = '0; t_write[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic exp_ir, exp_dr;
    for (int k = 0; k < 2; k++) begin
      exp_ir = busy[k] && !who_d[k] && mready && !reset;
      exp_dr = busy[k] &&  who_d[k] && mready && !reset;
      chk($sformatf("mvalid%0d", k), {31'b0, mvalid_w[k]}, {31'b0, busy[k]});
      chk($sformatf("iready%0d", k), {31'b0, iready_w[k]}, {31'b0, exp_ir});
      chk($sformatf("dready%0d", k), {31'b0, dready_w[k]}, {31'b0, exp_dr});
      chk($sformatf("idata%0d", k), idata_w[k], exp_ir ? mrdata : 32'h0);
      chk($sformatf("drdata%0d", k), drdata_w[k], exp_dr ? mrdata : 32'h0);
      if (busy[k]) begin
        chk($sformatf("maddr%0d", k), maddr_w[k], t_addr[k]);
        chk($sformatf("mwdata%0d", k), mwdata_w[k], t_wdata[k]);
        chk($sformatf("mwstb%0d", k), {28'b0, mwstb_w[k]}, {28'b0, t_wstb[k]});
        chk($sformatf("mwrite%0d", k), {31'b0, mwrite_w[k]}, {31'b0, t_write[k]});
      end
    end
    if (sb_on && (iready_w[1] || dready_w[1])) begin
      if (exp_q.size() == 0) chk("rr_extra_grant", 32'h1, 32'h0);
      else chk("rr_grant_order", {31'b0, dready_w[1]}, {31'b0, exp_q.pop_front()});
    end
  endtask

  task automatic model_step();
    bit take_d;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (busy[k]) begin
        if (mready) busy[k] = 1'b0;
      end else if (ivalid || dvalid) begin
        // Conflict: data wins under priority, otherwise the port not served last.
        take_d = dvalid && (!ivalid || prio[k] || !last_was_d[k]);
        busy[k] = 1'b1; who_d[k] = take_d; last_was_d[k] = take_d;
        t_addr[k]  = take_d ? daddr  : iaddr;
        t_wdata[k] = take_d ? dwdata : 32'h0;
        t_wstb[k]  = take_d ? dwstb  : 4'h0;
        t_write[k] = take_d ? dwrite : 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    check_all();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    ivalid = 1'b0; dvalid = 1'b0; mready = 1'b0; mrdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; drive_idle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clock); #1;
    do_reset();

    // Reset state
    @(negedge clock);
    chk("rst_maddr", maddr_w[0], 32'h0);
    chk("rst_mvalid", {31'b0, mvalid_w[0]}, 32'h0);
    chk("rst_mwstb", {28'b0, mwstb_w[1]}, 32'h0);
    @(posedge clock); #1;

    // Fetch only, zero-wait
    ivalid = 1'b1; iaddr = 32'h100;
    cycle();
    mready = 1'b1; mrdata = 32'h13;
    @(negedge clock);
    chk("fetch_maddr", maddr_w[0], 32'h100);
    chk("fetch_iready", {31'b0, iready_w[0]}, 32'h1);
    chk("fetch_idata", idata_w[0], 32'h13);
    @(posedge clock); #1;
    // Re-sync model: it has not yet seen the two edges above.
    model_reset();
    ivalid = 1'b0; mready = 1'b0;
    do_reset();

    // Store with three wait states
    dvalid = 1'b1; daddr = 32'h2000; dwdata = 32'hDEADBEEF; dwstb = 4'hF; dwrite = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("store_hold_maddr", maddr_w[0], 32'h2000);
    end
    mready = 1'b1; mrdata = 32'h5A5A;
    cycle();
    dvalid = 1'b0; mready = 1'b0;
    cycle();

    // Conflict under data priority: D, idle gap, then I
    ivalid = 1'b1; dvalid = 1'b1; iaddr = 32'h40; daddr = 32'h80; dwrite = 1'b0; mready = 1'b1;
    cycle();
    chk("dp_first_is_d", {31'b0, dready_w[0]}, 32'h1);
    dvalid = 1'b0;
    cycle();
    chk("dp_gap", {31'b0, mvalid_w[0]}, 32'h0);
    cycle();
    chk("dp_then_i", {31'b0, iready_w[0]}, 32'h1);
    ivalid = 1'b0; mready = 1'b0;
    cycle();

    // Round-robin alternation after reset
    do_reset();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    sb_on = 1'b1;
    ivalid = 1'b1; dvalid = 1'b1; mready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mrdata = $urandom;
      cycle();
    end
    sb_on = 1'b0;
    chk("rr_all_grants_seen", exp_q.size(), 32'h0);
    drive_idle();
    cycle();

    // Reset mid-DACT with mready high in the reset cycle
    dvalid = 1'b1; daddr = 32'h3000;
    cycle();
    reset = 1'b1; mready = 1'b1; dvalid = 1'b0;
    cycle();
    reset = 1'b0; mready = 1'b0;
    @(negedge clock);
    chk("abort_mvalid", {31'b0, mvalid_w[0]}, 32'h0);
    chk("abort_maddr", maddr_w[0], 32'h0);
    @(posedge clock); #1;

    // Stray mready while idle
    mready = 1'b1; mrdata = 32'hFFFF;
    cycle();
    cycle();
    mready = 1'b0;
    cycle();

    // Randomized traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 59) == 0);
      ivalid = $urandom_range(0, 1);
      dvalid = $urandom_range(0, 1);
      iaddr  = $urandom; daddr = $urandom; dwdata = $urandom;
      dwstb  = 4'($urandom_range(0, 15));
      dwrite = $urandom_range(0, 1);
      mready = ($urandom_range(0, 2) != 0);
      mrdata = $urandom;
      cycle();
    end
    reset = 1'b0;
    drive_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
